// File: rtl/stage3_pkg.sv
// stage3_pkg -- shared definitions for the stage-3 scoring generator.
//   state_t          : FSM state encoding (IDLE, PREP, TALK, OUT)
//   LFSR_SEED        : reset value of the luck LFSR
//   DEF_TARGET       : default ideal talk length in cycles
//   DEF_TOL_SHIFT    : default deviation right-shift per timing step
//   timing_score()   : maps a final talk length to a 0..7 timing score
package stage3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        TALK = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [2:0] LFSR_SEED     = 3'b001;
    localparam logic [7:0] DEF_TARGET    = 8'd100;
    localparam int         DEF_TOL_SHIFT = 2;

    // Score is 7 for a perfect length and drops by one for every
    // 2**shift cycles of deviation, bottoming out at 0.
    function automatic logic [2:0] timing_score(input logic [7:0] cnt,
                                                input logic [7:0] target,
                                                input int         shift);
        logic [7:0] dev;
        logic [7:0] steps;
        dev   = (cnt >= target) ? (cnt - target) : (target - cnt);
        steps = dev >> shift;
        return (steps > 8'd7) ? 3'd0 : (3'd7 - steps[2:0]);
    endfunction

endpackage

// File: rtl/lfsr3.sv
// lfsr3 -- free-running 3-bit maximal-length LFSR (period 7).
//   clk : clock, rising edge
//   rst : synchronous active-high reset, loads LFSR_SEED
//   q   : current LFSR value; sequence 001,010,101,011,111,110,100
module lfsr3
    import stage3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[1:0], q[2] ^ q[1]};
        end
    end

endmodule

// File: rtl/stage3_gen.sv
// stage3_gen -- stage-3 score generator.
// A run starts from IDLE, counts preparation effort in PREP, measures the
// talk length in TALK, then presents a scored record in OUT until the
// consumer takes it.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   start               : begin a run (IDLE only); latches pass2_i/bonus2_i
//   abort               : return to IDLE from any state
//   pass2_i, bonus2_i   : stage-2 result and bonus, latched at start
//   work                : effort strobe counted in PREP
//   prep_done, talk_end : pulses ending PREP and TALK
//   out_ready           : consumer acceptance
//   slide, timing       : slide-quality and report-timing scores
//   luck3               : LFSR sample taken on OUT entry
//   bonus2, pass2       : latched stage-2 values
//   out_valid           : record valid (state is OUT)
//   busy                : state is not IDLE
//   state_dbg           : current FSM state encoding (debug visibility)
//
// Build option: define STAGE3_GEN_TIMEOUT_EN to leave TALK for OUT with
// timing = 0 once 255 TALK cycles elapse without talk_end.
//
// Handshake: the record transfers on a rising edge where out_valid and
// out_ready are both high; out_valid, once raised, stays high and all
// record fields stay stable until that transfer (or abort/reset).
// out_ready while out_valid is low is ignored.
module stage3_gen
    import stage3_pkg::*;
#(
    parameter logic [7:0] TARGET    = DEF_TARGET,
    parameter int         TOL_SHIFT = DEF_TOL_SHIFT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pass2_i,
    input  logic [1:0] bonus2_i,
    input  logic       work,
    input  logic       prep_done,
    input  logic       talk_end,
    input  logic       out_ready,
    output logic [2:0] slide,
    output logic [2:0] timing,
    output logic [2:0] luck3,
    output logic [1:0] bonus2,
    output logic       pass2,
    output logic       out_valid,
    output logic       busy,
    output logic [1:0] state_dbg
);

    state_t     state;
    logic [4:0] work_cnt;
    logic [7:0] talk_cnt;
    logic [4:0] work_nx;
    logic [7:0] talk_nx;
    logic [2:0] lfsr_q;

    lfsr3 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Saturating next-count values; the cycle carrying prep_done/talk_end
    // is itself counted, so the decisions below use these.
    always_comb begin
        work_nx = work_cnt;
        if (work && (work_cnt != 5'd31)) begin
            work_nx = work_cnt + 5'd1;
        end
        talk_nx = talk_cnt;
        if (talk_cnt != 8'hFF) begin
            talk_nx = talk_cnt + 8'd1;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slide     <= 3'd0;
            timing    <= 3'd0;
            luck3     <= LFSR_SEED;
            bonus2    <= 2'd0;
            pass2     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            work_cnt  <= 5'd0;
            talk_cnt  <= 8'd0;
        end else if (abort) begin
            // Scores and luck are kept so the last record remains readable.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            work_cnt  <= 5'd0;
            talk_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pass2    <= pass2_i;
                        bonus2   <= bonus2_i;
                        work_cnt <= 5'd0;
                        talk_cnt <= 8'd0;
                        busy     <= 1'b1;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    work_cnt <= work_nx;
                    if (prep_done) begin
                        slide <= (work_nx >= 5'd28) ? 3'd7 : work_nx[4:2];
                        state <= TALK;
                    end
                end
                TALK: begin
                    talk_cnt <= talk_nx;
                    if (talk_end) begin
                        timing    <= timing_score(talk_nx, TARGET, TOL_SHIFT);
                        luck3     <= lfsr_q;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
`ifdef STAGE3_GEN_TIMEOUT_EN
                    else if (talk_nx == 8'hFF) begin
                        timing    <= 3'd0;
                        luck3     <= lfsr_q;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
`else
                    // Without the timeout, TALK waits for talk_end or abort.
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage3_gen.sv
// tb_stage3_gen -- directed self-checking bench for stage3_gen.
module tb_stage3_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pass2_i;
    logic [1:0] bonus2_i;
    logic       work;
    logic       prep_done;
    logic       talk_end;
    logic       out_ready;
    logic [2:0] slide;
    logic [2:0] timing;
    logic [2:0] luck3;
    logic [1:0] bonus2;
    logic       pass2;
    logic       out_valid;
    logic       busy;
    logic [1:0] state_dbg;

    int n_cmp;
    int n_bad;
    int edge_n;
    logic [2:0] seq [7];
    logic [2:0] exp_luck;

    stage3_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pass2_i   (pass2_i),
        .bonus2_i  (bonus2_i),
        .work      (work),
        .prep_done (prep_done),
        .talk_end  (talk_end),
        .out_ready (out_ready),
        .slide     (slide),
        .timing    (timing),
        .luck3     (luck3),
        .bonus2    (bonus2),
        .pass2     (pass2),
        .out_valid (out_valid),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of rising edges seen with rst low since the last reset.
    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic p, input logic [1:0] b);
        pass2_i  = p;
        bonus2_i = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        pass2_i  = ~p;
        bonus2_i = ~b;
    endtask

    // n work cycles, then a prep_done cycle (with work held if wk_done).
    task automatic do_prep(input int n, input logic wk_done);
        work = 1'b1;
        repeat (n) tick();
        work      = wk_done;
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
        work      = 1'b0;
    endtask

    // talk_end on TALK cycle n; records the luck value expected at OUT entry.
    task automatic do_talk(input int n);
        repeat (n - 1) tick();
        talk_end = 1'b1;
        tick();
        talk_end = 1'b0;
        exp_luck = seq[(edge_n - 1) % 7];
    endtask

    task automatic do_accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_cmp++;
        if ({slide, timing, bonus2, pass2, out_valid, busy} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {slide, timing, bonus2, pass2, out_valid, busy});
        end
        n_cmp++;
        if (luck3 !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_luck3: got %b expected 001", luck3);
        end
        n_cmp++;
        if (state_dbg !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_ignore();
        prep_done = 1'b1; talk_end = 1'b1; out_ready = 1'b1; work = 1'b1;
        repeat (2) tick();
        prep_done = 1'b0; talk_end = 1'b0; out_ready = 1'b0; work = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_idle: state=%0d busy=%b valid=%b expected 0/0/0",
                     state_dbg, busy, out_valid);
        end
        do_start(1'b0, 2'b01);
        talk_end = 1'b1;
        tick();
        talk_end = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_talk_end_in_prep: state=%0d busy=%b expected 1/1",
                     state_dbg, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_nominal();
        do_start(1'b1, 2'b10);
        do_prep(12, 1'b0);
        n_cmp++;
        if (state_dbg !== 2'd2 || slide !== 3'd3) begin
            n_bad++;
            $display("FAIL nominal_prep: state=%0d slide=%0d expected 2/3",
                     state_dbg, slide);
        end
        do_talk(100);
        n_cmp++;
        if (out_valid !== 1'b1 || timing !== 3'd7 || slide !== 3'd3) begin
            n_bad++;
            $display("FAIL nominal_out: valid=%b timing=%0d slide=%0d expected 1/7/3",
                     out_valid, timing, slide);
        end
        n_cmp++;
        if (pass2 !== 1'b1 || bonus2 !== 2'b10) begin
            n_bad++;
            $display("FAIL nominal_latch: pass2=%b bonus2=%b expected 1/10",
                     pass2, bonus2);
        end
        n_cmp++;
        if (luck3 !== exp_luck) begin
            n_bad++;
            $display("FAIL nominal_luck: got %b expected %b", luck3, exp_luck);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || timing !== 3'd7 ||
                slide !== 3'd3 || luck3 !== exp_luck) begin
                n_bad++;
                $display("FAIL nominal_hold%0d: valid=%b busy=%b timing=%0d slide=%0d luck=%b",
                         i, out_valid, busy, timing, slide, luck3);
            end
            tick();
        end
        do_accept();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            n_bad++;
            $display("FAIL nominal_accept: valid=%b busy=%b state=%0d expected 0/0/0",
                     out_valid, busy, state_dbg);
        end
    endtask

    task automatic test_abort();
        do_start(1'b0, 2'b11);
        do_prep(8, 1'b0);
        repeat (49) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: state=%0d valid=%b busy=%b expected 0/0/0",
                     state_dbg, out_valid, busy);
        end
        n_cmp++;
        if (slide !== 3'd2 || timing !== 3'd7) begin
            n_bad++;
            $display("FAIL abort_keep: slide=%0d timing=%0d expected 2/7",
                     slide, timing);
        end
    endtask

    task automatic test_saturation();
        do_start(1'b1, 2'b01);
        do_prep(40, 1'b0);
        do_talk(110);
        n_cmp++;
        if (slide !== 3'd7 || timing !== 3'd5 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_long: slide=%0d timing=%0d valid=%b expected 7/5/1",
                     slide, timing, out_valid);
        end
        n_cmp++;
        if (luck3 !== exp_luck) begin
            n_bad++;
            $display("FAIL sat_luck: got %b expected %b", luck3, exp_luck);
        end
        // start during OUT must not disturb the record.
        start = 1'b1; pass2_i = 1'b0; bonus2_i = 2'b10;
        repeat (3) tick();
        start = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd3 || out_valid !== 1'b1 || pass2 !== 1'b1 ||
            bonus2 !== 2'b01 || slide !== 3'd7 || timing !== 3'd5) begin
            n_bad++;
            $display("FAIL start_in_out: state=%0d valid=%b pass2=%b bonus2=%b slide=%0d timing=%0d",
                     state_dbg, out_valid, pass2, bonus2, slide, timing);
        end
        do_accept();
        // Work during the prep_done cycle counts: 19+1 = 20 -> slide 5.
        do_start(1'b0, 2'b00);
        do_prep(19, 1'b1);
        do_talk(30);
        n_cmp++;
        if (slide !== 3'd5 || timing !== 3'd0) begin
            n_bad++;
            $display("FAIL sat_short: slide=%0d timing=%0d expected 5/0",
                     slide, timing);
        end
        n_cmp++;
        if (luck3 !== exp_luck) begin
            n_bad++;
            $display("FAIL short_luck: got %b expected %b", luck3, exp_luck);
        end
        do_accept();
    endtask

    task automatic test_timeout();
        do_start(1'b1, 2'b11);
        do_prep(4, 1'b0);
`ifdef STAGE3_GEN_TIMEOUT_EN
        repeat (254) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || state_dbg !== 2'd2) begin
            n_bad++;
            $display("FAIL timeout_early: valid=%b state=%0d expected 0/2",
                     out_valid, state_dbg);
        end
        tick();
        exp_luck = seq[(edge_n - 1) % 7];
        n_cmp++;
        if (out_valid !== 1'b1 || timing !== 3'd0 || luck3 !== exp_luck) begin
            n_bad++;
            $display("FAIL timeout_out: valid=%b timing=%0d luck=%b expected 1/0/%b",
                     out_valid, timing, luck3, exp_luck);
        end
        do_accept();
`else
        for (int i = 0; i < 10; i++) begin
            repeat (100) tick();
            n_cmp++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL no_timeout%0d: busy=%b valid=%b expected 1/0",
                         i, busy, out_valid);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset_override();
        do_start(1'b1, 2'b11);
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        n_cmp++;
        if (state_dbg !== 2'd0 || busy !== 1'b0 || slide !== 3'd0 ||
            timing !== 3'd0 || luck3 !== 3'b001 || pass2 !== 1'b0 || bonus2 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_override: state=%0d busy=%b slide=%0d timing=%0d luck=%b pass2=%b bonus2=%b",
                     state_dbg, busy, slide, timing, luck3, pass2, bonus2);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        seq = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
        exp_luck  = 3'b001;
        rst = 1'b1; start = 1'b0; abort = 1'b0; pass2_i = 1'b0; bonus2_i = 2'd0;
        work = 1'b0; prep_done = 1'b0; talk_end = 1'b0; out_ready = 1'b0;
        test_reset();
        test_ignore();
        test_nominal();
        test_abort();
        test_saturation();
        test_timeout();
        test_reset_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
